decode_issue: RTL

DECODE_ISSUE -- requirements
Module: decode_issue

---
 rtl/decode_issue.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/decode_issue.sv
// Decode stage plus D->E pipeline register for a MIPS-style core subset.
// Latency: one cycle from a decodable instrD to the E outputs.
// Backpressure: stallE holds the E register; stallD asks decode to hold on a load-use hazard.
//
// Ports: clk/rst_n (async active-low); instrD/validD/rd1D/rd2D from decode;
// stallE/flushE from downstream control; stallD back to fetch/decode;
// *E outputs are the registered execute-stage controls and operands;
// illegalE/illegal_cnt report dropped undecodable instructions.
module decode_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instrD,
    input  logic        validD,
    input  logic [31:0] rd1D,
    input  logic [31:0] rd2D,
    input  logic        stallE,
    input  logic        flushE,
    output logic        stallD,
    output logic        validE,
    output logic [1:0]  ALUOpE,
    output logic [3:0]  ex_cmdE,
    output logic        branchE,
    output logic        aluSrcE,
    output logic        regWriteE,
    output logic        memWriteE,
    output logic        memToRegE,
    output logic        regDstE,
    output logic [31:0] input1E,
    output logic [31:0] input2E,
    output logic [4:0]  rtE,
    output logic [4:0]  rdE,
    output logic        illegalE,
    output logic [7:0]  illegal_cnt
);

    typedef struct packed {
        logic        valid;
        logic [1:0]  alu_op;
        logic [3:0]  ex_cmd;
        logic        branch;
        logic        alu_src;
        logic        reg_write;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_dst;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } e_t;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_d;
    logic [4:0]  rt_d;
    logic [31:0] imm_d;
    logic        legal;
    e_t          dec;
    e_t          e_q;
    e_t          e_n;
    logic        drop_illegal;

    assign opcode = instrD[31:26];
    assign funct  = instrD[5:0];
    assign rs_d   = instrD[25:21];
    assign rt_d   = instrD[20:16];
    assign imm_d  = {{16{instrD[15]}}, instrD[15:0]};

    // Instruction decode; ex_cmd stays 0000 for every non-R-type class.
    always_comb begin
        dec       = '0;
        legal     = 1'b1;
        dec.valid = 1'b1;
        dec.in1   = rd1D;
        dec.rt    = rt_d;
        dec.rd    = instrD[15:11];
        case (opcode)
            6'b000000: begin
                dec.alu_op    = 2'd2;
                dec.reg_write = 1'b1;
                dec.reg_dst   = 1'b1;
                case (funct)
                    6'b100000: dec.ex_cmd = 4'b0010;
                    6'b100010: dec.ex_cmd = 4'b0110;
                    6'b100100: dec.ex_cmd = 4'b0000;
                    6'b100101: dec.ex_cmd = 4'b0001;
                    6'b011000: dec.ex_cmd = 4'b1111;
                    default:   legal      = 1'b0;
                endcase
            end
            6'b100011: begin
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
            end
            6'b101011: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            6'b000100: begin
                dec.alu_op = 2'd1;
                dec.branch = 1'b1;
            end
            6'b001000: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        dec.in2 = dec.alu_src ? imm_d : rd2D;
    end

    // Load-use hazard against the load sitting in E; masked whenever E is
    // being held or squashed, since decode advancing is then irrelevant.
    always_comb begin
        stallD = 1'b0;
        if (!stallE && !flushE && e_q.valid && e_q.mem_to_reg && validD &&
            (e_q.rt != 5'd0) && ((e_q.rt == rs_d) || (e_q.rt == rt_d))) begin
            stallD = 1'b1;
        end
    end

    // Next E contents, strictly in priority order; anything not captured or
    // held becomes a bubble (all zeros).
    always_comb begin
        e_n          = '0;
        drop_illegal = 1'b0;
        if (flushE) begin
            e_n = '0;
        end else if (stallE) begin
            e_n = e_q;
        end else if (stallD) begin
            e_n = '0;
        end else if (validD && !legal) begin
            drop_illegal = 1'b1;
        end else if (validD) begin
            e_n = dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q         <= '0;
            illegalE    <= 1'b0;
            illegal_cnt <= 8'd0;
        end else begin
            e_q      <= e_n;
            illegalE <= drop_illegal;
            if (drop_illegal && (illegal_cnt != 8'hFF)) begin
                illegal_cnt <= illegal_cnt + 8'd1;
            end
        end
    end

    assign validE    = e_q.valid;
    assign ALUOpE    = e_q.alu_op;
    assign ex_cmdE   = e_q.ex_cmd;
    assign branchE   = e_q.branch;
    assign aluSrcE   = e_q.alu_src;
    assign regWriteE = e_q.reg_write;
    assign memWriteE = e_q.mem_write;
    assign memToRegE = e_q.mem_to_reg;
    assign regDstE   = e_q.reg_dst;
    assign input1E   = e_q.in1;
    assign input2E   = e_q.in2;
    assign rtE       = e_q.rt;
    assign rdE       = e_q.rd;

endmodule
